fir_out_buf: RTL and testbench

Output stage directly downstream of the single-MAC FIR controller/accumulator. Captures the 36-bit accumulator value on each result write strobe and converts it to a 16-bit output sample with round-half-up, arithmetic shift and saturation. Buffers the samples in a small FIFO and presents them on a valid/ready stream. Counts samples per frame and flags frame completion and overflow.

---
 rtl/fir_out_buf.sv | 172 +++++++++++++++++
 tb/tb_fir_out_buf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_buf.sv
// Show-ahead synchronous FIFO with registered count/full/empty.
// Latency: push visible at the head one cycle after the push edge.
// Backpressure: push_rdy drops only when full and no pop this cycle.
module fir_out_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic          push_rdy,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full, r_empty;
  logic          w_pop, w_push;
  logic [AW:0]   w_count_nxt;

  assign w_pop    = !r_empty && pop_rdy;
  assign push_rdy = !r_full || w_pop;
  assign w_push   = push_vld && push_rdy;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + (AW+1)'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat;
  end

  assign pop_vld = !r_empty;
  assign pop_dat = r_empty ? '0 : r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = r_full;
  assign empty   = r_empty;
endmodule

// FIR output stage: round/shift/saturate accumulator, buffer, stream out.
// Latency: wr_en in cycle N -> sample at the head in cycle N+2.
// Backpressure: out_ready stalls the FIFO; samples arriving when full are dropped (ovf).
module fir_out_buf #(
  parameter int ACC_W = 36,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int NSAMP = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] acc_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             sat,
  output logic             ovf,
  output logic             done
);
  localparam int EW = ACC_W + 1;
  localparam int CW = $clog2(NSAMP + 1);
  // Half-LSB rounding constant; collapses to zero when SHIFT is zero.
  localparam logic [EW:0]          RC_X = (EW+1)'(1) << SHIFT;
  localparam logic signed [EW-1:0] RC   = RC_X[EW:1];
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CW-1:0]        NSAMP_C = CW'(NSAMP);

  logic signed [EW-1:0] w_ext, w_sum, w_shr;
  logic                 w_hi, w_lo;
  logic [OUT_W-1:0]     w_conv;
  logic                 w_push_rdy, w_push_acc, w_fifo_rst;

  logic [OUT_W-1:0]     r_s1_dat;
  logic                 r_s1_vld;
  logic [CW-1:0]        r_samp_cnt;
  logic                 r_sat, r_ovf, r_done;

  assign w_ext = {acc_in[ACC_W-1], acc_in};
  assign w_sum = w_ext + RC;
  assign w_shr = w_sum >>> SHIFT;
  assign w_hi  = (w_shr > MAXV);
  assign w_lo  = (w_shr < MINV);

  always_comb begin
    w_conv = w_shr[OUT_W-1:0];
    if (w_hi)      w_conv = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_lo) w_conv = {1'b1, {(OUT_W-1){1'b0}}};
  end

  assign w_push_acc = r_s1_vld && w_push_rdy;
  assign w_fifo_rst = rst || clr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_s1_vld   <= 1'b0;
      r_s1_dat   <= '0;
      r_samp_cnt <= '0;
      r_sat      <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_s1_vld <= wr_en;
      if (wr_en) begin
        r_s1_dat <= w_conv;
        if (w_hi || w_lo) r_sat <= 1'b1;
      end
      if (r_s1_vld && !w_push_rdy) r_ovf <= 1'b1;
      // Counter parks at NSAMP; later pushes still go into the FIFO.
      if (w_push_acc && (r_samp_cnt != NSAMP_C)) begin
        r_samp_cnt <= r_samp_cnt + CW'(1);
        if (r_samp_cnt == NSAMP_C - CW'(1)) r_done <= 1'b1;
      end
    end
  end

  fir_out_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (w_fifo_rst),
    .push_vld (r_s1_vld),
    .push_dat (r_s1_dat),
    .push_rdy (w_push_rdy),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (out_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign sat  = r_sat;
  assign ovf  = r_ovf;
  assign done = r_done;
endmodule

// File: tb/tb_fir_out_buf.sv
// Bench for fir_out_buf: queue-based reference model checked every cycle plus directed literal checks.
module tb_fir_out_buf;
  localparam int ACC_W = 36;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int NSAMP = 32;

  logic             clk = 1'b0;
  logic             rst, clr, wr_en, out_ready;
  logic [ACC_W-1:0] acc_in;
  logic [OUT_W-1:0] out_data;
  logic             out_valid, full, empty, sat, ovf, done;
  logic [AW:0]      count;

  always #5 clk = ~clk;

  fir_out_buf #(
    .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
    .DEPTH(DEPTH), .AW(AW), .NSAMP(NSAMP)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .acc_in(acc_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .sat(sat), .ovf(ovf), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion: floor((v + half) / 2^SHIFT), then clamp to OUT_W signed.
  function automatic logic [15:0] conv(input logic [ACC_W-1:0] acc, output bit clamp);
    longint v, a, d, q;
    v = $signed(acc);
    d = longint'(1) << SHIFT;
    a = v + ((SHIFT > 0) ? (d / 2) : 0);
    q = a / d;
    if ((a < 0) && ((a % d) != 0)) q = q - 1;
    clamp = 1'b0;
    if (q > 32767) begin
      q = 32767; clamp = 1'b1;
    end else if (q < -32768) begin
      q = -32768; clamp = 1'b1;
    end
    return q[15:0];
  endfunction

  bit          m_s1_vld = 1'b0;
  logic [15:0] m_s1_val = '0;
  logic [15:0] m_q[$];
  int          m_cnt = 0;
  bit          m_sat = 1'b0, m_ovf = 1'b0, m_done = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : mdl
    bit pop, cl;
    if (rst || clr) begin
      m_s1_vld = 1'b0;
      m_q.delete();
      m_cnt  = 0;
      m_sat  = 1'b0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
    end else begin
      pop = (m_q.size() > 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (m_s1_vld) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(m_s1_val);
          if (m_cnt < NSAMP) m_cnt++;
          if (m_cnt == NSAMP) m_done = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_s1_vld = wr_en;
      if (wr_en) begin
        m_s1_val = conv(acc_in, cl);
        if (cl) m_sat = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_out_valid", out_valid, m_q.size() != 0);
      check("m_empty", empty, m_q.size() == 0);
      check("m_full", full, m_q.size() == DEPTH);
      check("m_count", count, m_q.size());
      if (m_q.size() != 0) check("m_out_data", out_data, m_q[0]);
      check("m_sat", sat, m_sat);
      check("m_ovf", ovf, m_ovf);
      check("m_done", done, m_done);
    end
  end

  // One sample with out_ready high; head checked two edges after the strobe.
  task automatic one(input logic [ACC_W-1:0] a, input logic [15:0] e, input string nm);
    out_ready = 1'b1;
    wr_en = 1'b1;
    acc_in = a;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check({nm, "_vld"}, out_valid, 1'b1);
    check(nm, out_data, e);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
    wr_en = 1'b1; acc_in = 36'h000008000;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 0);
    check("rst_data", out_data, 16'h0000);
    check("rst_flags", {sat, ovf, done}, 3'b000);
    repeat (4) begin
      @(negedge clk);
      check("rst_no_sample", out_valid, 1'b0);
    end

    one(36'h000008000, 16'h0001, "rnd_8000");
    one(36'h000004000, 16'h0001, "rnd_4000");
    one(36'h000003FFF, 16'h0000, "rnd_3fff");
    one(36'hFFFFFC000, 16'h0000, "rnd_m16384");
    one(36'hFFFFF8000, 16'hFFFF, "rnd_m32768");
    check("rnd_no_sat", sat, 1'b0);

    one(36'h7FFFFFFFF, 16'h7FFF, "sat_pos");
    check("sat_pos_flag", sat, 1'b1);
    one(36'h800000000, 16'h8000, "sat_neg");
    pulse_clr();
    check("sat_clr", sat, 1'b0);
    // Lands exactly on 0x7FFF; another half-LSB rounds it past the top.
    one(36'h03FFF8000, 16'h7FFF, "sat_exact");
    check("sat_exact_flag", sat, 1'b0);
    one(36'h03FFFC000, 16'h7FFF, "sat_round");
    check("sat_round_flag", sat, 1'b1);

    pulse_clr();
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      wr_en = 1'b1;
      acc_in = 36'(k) << 15;
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("ovf_count", count, 8);
    check("ovf_full", full, 1'b1);
    check("ovf_flag", ovf, 1'b1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("ovf_drain", out_data, k);
      @(negedge clk);
    end
    check("ovf_empty", empty, 1'b1);

    pulse_clr();
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wr_en = 1'b1;
      acc_in = 36'(k) << 15;
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("fp_prefill", count, 8);
    wr_en = 1'b1;
    acc_in = 36'(100) << 15;
    @(negedge clk);
    wr_en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("fp_count", count, 8);
    check("fp_full", full, 1'b1);
    check("fp_ovf", ovf, 1'b0);
    out_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      check("fp_drain", out_data, k);
      @(negedge clk);
    end
    check("fp_last", out_data, 16'd100);
    @(negedge clk);
    check("fp_empty", empty, 1'b1);

    pulse_clr();
    out_ready = 1'b1;
    for (int i = 0; i < NSAMP; i++) begin
      wr_en = 1'b1;
      acc_in = 36'(i) << 15;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("frame_done_early", done, 1'b0);
    @(negedge clk);
    check("frame_done", done, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    wr_en = 1'b1; acc_in = 36'h7FFFFFFFF;
    @(negedge clk);
    acc_in = 36'(5) << 15;
    @(negedge clk);
    acc_in = 36'(6) << 15;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("mid_count", count, 3);
    check("mid_sat", sat, 1'b1);
    check("mid_done", done, 1'b1);
    clr = 1'b1; wr_en = 1'b1; acc_in = 36'h000008000;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0;
    check("clr_count", count, 0);
    check("clr_valid", out_valid, 1'b0);
    check("clr_flags", {sat, ovf, done}, 3'b000);
    repeat (3) begin
      @(negedge clk);
      check("clr_no_sample", out_valid, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
